// File: rtl/k_sequencer.sv
// SHA-2 round-constant sequencer: steps through the SHA-256 or SHA-512 K table under start/adv.
// Optional registered K[round_idx+1] lookahead on k_next when K_LOOKAHEAD_EN is defined.
module k_sequencer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  output logic [WORD_W-1:0] k_out,
  output logic [WORD_W-1:0] k_next,
  output logic [6:0]        round_idx,
  output logic              k_valid,
  output logic              last,
  output logic              done
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);
  localparam logic [6:0] IDLE_IDX = 7'h7F;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("k_sequencer: WORD_W must be 32 or 64");
  end

  localparam logic [31:0] K256 [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Any index past the table (including the idle sentinel) reads as zero.
  function automatic logic [WORD_W-1:0] k_lookup(input logic [6:0] idx);
    if (idx >= 7'(ROUNDS))
      return '0;
    else if (WORD_W == 32)
      return WORD_W'(K256[idx[5:0]]);
    else
      return WORD_W'(K512[idx]);
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_d;
  logic [6:0]        idx_d;
  logic              done_d;
  logic [WORD_W-1:0] k_out_d;

  always_comb begin
    state_d = state;
    idx_d   = round_idx;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 7'd0;
        end
      end
      RUN: begin
        if (start) begin
          idx_d = 7'd0;
        end else if (adv) begin
          if (round_idx == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = IDLE_IDX;
            done_d  = 1'b1;
          end else begin
            idx_d = round_idx + 7'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDLE_IDX;
      end
    endcase
    k_out_d = k_lookup(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_idx <= IDLE_IDX;
      k_out     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      round_idx <= idx_d;
      k_out     <= k_out_d;
      done      <= done_d;
    end
  end

  assign k_valid = (state == RUN);
  assign last    = (state == RUN) && (round_idx == LAST_IDX);

`ifdef K_LOOKAHEAD_EN
  logic [WORD_W-1:0] k_next_q;

  // Second read port one index ahead; the table tail naturally yields zero at the last round.
  always_ff @(posedge clk) begin
    if (rst)
      k_next_q <= '0;
    else if (state_d == RUN)
      k_next_q <= k_lookup(idx_d + 7'd1);
    else
      k_next_q <= '0;
  end

  assign k_next = k_next_q;
`else
  assign k_next = '0;
`endif

endmodule

// File: doc/k_sequencer.md
# k_sequencer

Parametrised SHA-2 round-constant sequencer. It holds the full K table for either the SHA-224/256 family (64 × 32-bit) or the SHA-384/512 family (80 × 64-bit). It steps through the table under a start/advance handshake and presents a registered constant each round to the compression datapath. It sits beside the round-function pipeline and replaces direct index-driven K lookup, owning the round counter and the end-of-block signalling.

## Interface

- WORD_W, 32, constant width and table select: 32 selects the SHA-256 K table, 64 selects the SHA-512 K table; any other value is an elaboration error.
- ROUNDS (localparam), 64 when WORD_W=32 and 80 when WORD_W=64; not overridable.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  begin (or restart) a constant sequence at round 0.
- adv  in  1  consumer accepted the current constant; step to the next round.
- k_out  out  WORD_W  registered constant K[round_idx]; 0 when not valid.
- k_next  out  WORD_W  K[round_idx+1] lookahead (see Configuration).
- round_idx  out  7  current round index; 7'h7F when idle.
- k_valid  out  1  k_out holds a live constant.
- last  out  1  k_valid and round_idx == ROUNDS-1.
- done  out  1  one-cycle pulse after the final constant is accepted.

## Operation

- States:
  - IDLE: k_valid=0, round_idx=7'h7F, k_out=0.
  - RUN: k_valid=1.
- Reset: on rst=1 at a clock edge, the block enters IDLE.
  - All outputs clear: k_out=0, k_next=0, k_valid=0, last=0, done=0, round_idx=7'h7F.
  - rst has priority over start and adv.
- IDLE → RUN: start=1 loads round_idx=0 and k_out=K[0].
- RUN, adv=1, round_idx < ROUNDS-1: round_idx increments by 1 and k_out=K[round_idx+1].
- RUN, adv=1, round_idx == ROUNDS-1: transition to IDLE.
  - round_idx=7'h7F, k_out=0, k_valid=0.
  - done=1 for exactly one cycle.
- RUN, adv=0: all outputs hold, so stalls of any length are allowed.
- start=1 in RUN aborts the sequence and reloads round 0, with no done pulse. start wins over a simultaneous adv, including at the last round.
- adv=1 in IDLE is ignored.
- start=1 in the same cycle as done=1: done still pulses and RUN resumes at round 0 the next cycle.
- Arithmetic: round_idx is a 7-bit unsigned counter that never exceeds ROUNDS-1 in RUN. The value 7'h7F is the idle sentinel and reads K as 0.
- Table contents:
  - WORD_W=32: the 64 standard SHA-256 constants (FIPS 180-4).
  - WORD_W=64: the 80 standard SHA-512 constants.

## Timing

- start sampled at edge t → k_valid=1, round_idx=0, k_out=K[0] visible after edge t; latency 1 cycle.
- Each adv sampled at an edge with k_valid=1 → the next constant is visible after that same edge. Sustained throughput is one constant per cycle with adv held high.
- A full unstalled sequence occupies ROUNDS cycles of k_valid.
- done asserts in the cycle after the final accept, concurrent with k_valid=0.
- All outputs are registered except last, which decodes registered state only and has no input-to-output combinational path.

## Configuration

- K_LOOKAHEAD_EN defined:
  - k_next is a registered output carrying K[round_idx+1] while k_valid=1.
  - k_next=0 at the last round and in IDLE.
  - It updates on the same edges as k_out, so pipelined datapaths can precompute K+W one round early.
- K_LOOKAHEAD_EN undefined:
  - k_next is tied to 0.
  - The second table read port and register are not built.

## Test plan

- Reset then idle (WORD_W=32): rst=1 for 2 cycles, then start=0 → round_idx=7'h7F, k_out=0, k_valid=0, done=0; adv pulses cause no change.
- Full SHA-256 sequence: start, then adv held high.
  - Cycle 1 gives k_out=32'h428a2f98 at round 0.
  - Round 1 gives 32'h71374491; round 63 gives 32'hc67178f2 with last=1.
  - Next cycle: done=1, k_valid=0, k_out=0.
  - Exactly 64 valid cycles.
- Full SHA-512 sequence (WORD_W=64), adv high:
  - Round 0 gives 64'h428a2f98d728ae22 and round 1 gives 64'h7137449123ef65cd.
  - Round 79 gives 64'h6c44198c4a475817 with last=1.
  - Then done pulses once; 80 valid cycles.
- Stall and restart:
  - adv low for 5 cycles at round 10 → k_out holds 32'h243185be.
  - start at round 20 together with adv → next cycle round_idx=0, k_out=32'h428a2f98, no done.
- Reset mid-run: rst=1 at round 40 → next cycle IDLE outputs, no done pulse. With K_LOOKAHEAD_EN, round 0 shows k_next=32'h71374491 and round 63 shows k_next=0.
